uart_tx_fifo: RTL

Buffered feeder placed directly upstream of the UART transmitter. Accepts bytes from the host-side logic (ALU/interface FSM) through a single-cycle write strobe and stores them in a small circular FIFO. Drains the FIFO one byte at a time into the transmitter by presenting `tx_data` and pulsing `tx_start`, then waiting for the transmitter's `tx_done_tick` before issuing the next byte.

---
 rtl/uart_tx_fifo.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small circular byte FIFO that feeds a UART transmitter.
// Bytes are written with a one-cycle strobe. A two-state controller pops one
// byte at a time, presents it on tx_data_o with a one-cycle tx_start_o pulse,
// and then waits for tx_done_tick_i before it issues the next byte.
// Optional feature macro: UART_TX_FIFO_OVF_EN adds a sticky overflow flag
// (overflow_o) and its clear input (ovf_clr_i).
module uart_tx_fifo #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               wr_i,
  input  logic [NB_DATA-1:0] w_data_i,
  input  logic               tx_done_tick_i,
  output logic               tx_start_o,
  output logic [NB_DATA-1:0] tx_data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [NB_ADDR:0]   count_o,
  output logic               busy_o
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic               overflow_o,
  input  logic               ovf_clr_i
`endif
);

  localparam int DEPTH = 1 << NB_ADDR;
  localparam logic [NB_ADDR:0] DEPTH_C = (NB_ADDR+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  logic [NB_DATA-1:0] mem_q [DEPTH];
  logic [NB_ADDR-1:0] wptr_q, wptr_d;
  logic [NB_ADDR-1:0] rptr_q, rptr_d;
  logic [NB_ADDR:0]   count_q, count_d;
  state_t             state_q, state_d;
  logic               tx_start_q, tx_start_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               full, empty;
  logic               push, pop;

  // Flags come from the registered count, so they lag the write/pop by one edge.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A write into a full FIFO is dropped even if the controller pops this cycle.
  assign push = wr_i && !full;

  // Controller next-state and output decode.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          tx_data_d  = mem_q[rptr_q];
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (tx_done_tick_i) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer and occupancy next-state; a push and pop together leave count alone.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= w_data_i;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a set in the same cycle as a clear takes priority.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_i)     ovf_d = 1'b0;
    if (wr_i && full)  ovf_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge clk_i) begin
    if (reset_i) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign overflow_o = ovf_q;
`endif

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign busy_o     = busy_q;

endmodule
